// File: rtl/md_unit_param.sv
// Multi-cycle MULT/DIV unit with HI/LO registers for the E stage of a 5-stage MIPS pipeline.
// Define MD_MADD_EN to enable MADD/MADDU (op 6/7); otherwise those ops are no-ops.
module md_unit_param #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_sel,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam int DW         = 2 * WIDTH;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MADDU = 3'd7
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    op_e op_in;
    assign op_in = op_e'(op);

    function automatic logic is_launch(input op_e o);
`ifdef MD_MADD_EN
        return (o != OP_MTHI) && (o != OP_MTLO);
`else
        return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
`endif
    endfunction

    // Operands are extended to 2*WIDTH so the product never wraps early and
    // signed MIN / -1 yields +2^(WIDTH-1), whose low half is MIN with remainder 0.
    logic                 signed_op;
    logic [DW-1:0]        ea, eb, eb_safe, prod, quot, rem;
    assign signed_op = (op_q == OP_MULT) || (op_q == OP_DIV) || (op_q == OP_MADD);
    assign ea        = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign eb        = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign eb_safe   = (b_q == '0) ? DW'(1) : eb;
    assign prod      = ea * eb;

    always_comb begin
        quot = '0;
        rem  = '0;
        if (signed_op) begin
            quot = $signed(ea) / $signed(eb_safe);
            rem  = $signed(ea) % $signed(eb_safe);
        end else begin
            quot = ea / eb_safe;
            rem  = ea % eb_safe;
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_launch(op_in)) begin
                        a_d     = a;
                        b_d     = b;
                        op_d    = op_in;
                        state_d = RUN;
                        cnt_d   = ((op_in == OP_DIV) || (op_in == OP_DIVU)) ?
                                  CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                    end else if (op_in == OP_MTHI) begin
                        hi_d = a;
                    end else if (op_in == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            RUN: begin
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    case (op_q)
                        OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero leaves HI/LO untouched.
                            if (b_q != '0) begin
                                lo_d = quot[WIDTH-1:0];
                                hi_d = rem[WIDTH-1:0];
                            end
                        end
`ifdef MD_MADD_EN
                        OP_MADD, OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod;
`endif
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and overrides all inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign stall_req = busy | (start & is_launch(op_in));
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign rd_data   = rd_sel ? hi_q : lo_q;

endmodule
